// File: rtl/memory_access_unit.sv
// memory_access_unit: request-side front end for DataMemory.
// It accepts one load or store at a time over a valid/ready handshake and
// drives the memory pins from registers. It captures the registered read data
// one cycle after issue and returns a completion over a second handshake.
// Requests to addresses at or above MEMORY_SIZE never write the memory; their
// completion reports resp_error.
// Optional feature macro: MAU_PERF_COUNTER_EN adds saturating load/store
// completion counters (load_count, store_count).
module memory_access_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEMORY_SIZE   = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_error,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_write,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
`ifdef MAU_PERF_COUNTER_EN
  ,
  output logic [15:0]              load_count,
  output logic [15:0]              store_count
`endif
);

  // One extra bit so the range bound itself is representable for any width.
  localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH+1)'(MEMORY_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   wr_reg;   // captured request type, 1 = store
  logic   err_reg;  // captured out-of-range flag
  logic   accept;
  logic   resp_fire;

  assign req_ready  = (state_reg == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_reg == RESP);
  assign resp_fire  = resp_valid && resp_ready;
  assign resp_error = err_reg;
  // The write strobe is combinational so a reset arriving during ISSUE
  // suppresses the write in that same cycle.
  assign mem_write  = (state_reg == ISSUE) && wr_reg && !err_reg && !reset;

  // State register plus request capture and load-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      wr_reg      <= 1'b0;
      err_reg     <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      resp_data   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        wr_reg      <= req_write;
        err_reg     <= ({1'b0, req_address} >= MEM_LIMIT);
        mem_address <= req_address;
        mem_wdata   <= req_data;
        resp_data   <= '0;  // stores and errors complete with zero data
      end
      if (state_reg == CAPTURE) begin
        resp_data <= err_reg ? '0 : mem_rdata;
      end
    end
  end

  // Next-state logic: loads take the extra CAPTURE cycle, stores skip it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = wr_reg ? RESP : CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (resp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef MAU_PERF_COUNTER_EN
  // Saturating per-type completion counters, erroring requests included.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_count  <= 16'd0;
      store_count <= 16'd0;
    end else if (resp_fire) begin
      if (wr_reg) begin
        if (store_count != 16'hFFFF) store_count <= store_count + 16'd1;
      end else begin
        if (load_count != 16'hFFFF) load_count <= load_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed testbench for memory_access_unit with a behavioural DataMemory
// (registered read, synchronous write) attached to the memory pins.
module tb_memory_access_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 1024;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_error;
  logic [AW-1:0] mem_address;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MAU_PERF_COUNTER_EN
  logic [15:0]   load_count;
  logic [15:0]   store_count;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int mw_count   = 0;
  int accepts    = 0;

  memory_access_unit #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEMORY_SIZE(MS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_address(req_address),
    .req_data(req_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_error(resp_error),
    .mem_address(mem_address),
    .mem_write(mem_write),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MAU_PERF_COUNTER_EN
    ,
    .load_count(load_count),
    .store_count(store_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DataMemory; out-of-range reads return junk so the unit's
  // error gating of resp_data is exercised.
  logic [DW-1:0] mem_model [0:MS-1];
  initial begin
    for (int i = 0; i < MS; i++) mem_model[i] = '0;
  end
  always @(posedge clk) begin
    if (mem_write) mem_model[mem_address[9:0]] <= mem_wdata;
    mem_rdata <= (mem_address < 32'd1024) ? mem_model[mem_address[9:0]] : 32'hBAD0BAD0;
  end

  // Event monitors: write strobes seen by the memory, and accepted requests.
  always @(posedge clk) begin
    if (mem_write === 1'b1) mw_count++;
    if (req_valid === 1'b1 && req_ready === 1'b1) accepts++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction, called on a negedge and returning on a negedge
  // with the unit back in IDLE. stall = cycles resp_ready is held low once
  // resp_valid is up.
  task automatic do_req(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int stall, input int exp_lat,
                        input logic [31:0] exp_d, input logic exp_e, input logic exp_mw);
    int lat;
    int n;
    req_valid   = 1'b1;
    req_write   = w;
    req_address = a;
    req_data    = d;
    resp_ready  = (stall == 0);
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs: only the accept edge may sample them.
    req_valid   = 1'b0;
    req_write   = ~w;
    req_address = 32'h5A5A5A5A;
    req_data    = 32'hFFFF0000;
    check({tag, ".issue_mem_write"}, {31'd0, mem_write}, {31'd0, exp_mw});
    check({tag, ".issue_mem_address"}, mem_address, a);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".resp_data"}, resp_data, exp_d);
    check({tag, ".resp_error"}, {31'd0, resp_error}, {31'd0, exp_e});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".stall_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, ".stall_data"}, resp_data, exp_d);
      check({tag, ".stall_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check({tag, ".done_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, ".done_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  int mw0;
  int acc0;
  int n;
`ifdef MAU_PERF_COUNTER_EN
  logic [15:0] lc0;
  logic [15:0] sc0;
`endif

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_address = '0;
    req_data    = '0;
    resp_ready  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst.req_ready", {31'd0, req_ready}, 32'd0);
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.mem_write", {31'd0, mem_write}, 32'd0);
    check("rst.mem_address", mem_address, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    check("rst.resp_data", resp_data, 32'd0);
    check("rst.resp_error", {31'd0, resp_error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst.req_ready_after", {31'd0, req_ready}, 32'd1);

    // Store then load back, in range
    mw0 = mw_count;
    do_req("st5", 1'b1, 32'd5, 32'hDEADBEEF, 0, 2, 32'd0, 1'b0, 1'b1);
    check("st5.write_count", 32'(mw_count - mw0), 32'd1);
    do_req("ld5", 1'b0, 32'd5, 32'h0, 0, 3, 32'hDEADBEEF, 1'b0, 1'b0);

    // Out-of-range store and load at exactly MEMORY_SIZE
    mw0 = mw_count;
    do_req("st1024", 1'b1, 32'd1024, 32'hCAFEF00D, 0, 2, 32'd0, 1'b1, 1'b0);
    check("st1024.write_count", 32'(mw_count - mw0), 32'd0);
    do_req("ld1024", 1'b0, 32'd1024, 32'h0, 0, 3, 32'd0, 1'b1, 1'b0);
    // Last in-range word
    do_req("st1023", 1'b1, 32'd1023, 32'h01020304, 0, 2, 32'd0, 1'b0, 1'b1);
    do_req("ld1023", 1'b0, 32'd1023, 32'h0, 0, 3, 32'h01020304, 1'b0, 1'b0);

    // Load with resp_ready held low for 10 cycles
    do_req("ldstall", 1'b0, 32'd5, 32'h0, 10, 3, 32'hDEADBEEF, 1'b0, 1'b0);

    // Reset during ISSUE of a store must not write
    do_req("st7", 1'b1, 32'd7, 32'hAAAA5555, 0, 2, 32'd0, 1'b0, 1'b1);
    mw0 = mw_count;
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_address = 32'd7;
    req_data    = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("abort.mem_write", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort.resp_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    check("abort.write_count", 32'(mw_count - mw0), 32'd0);
    check("abort.req_ready", {31'd0, req_ready}, 32'd1);
    do_req("ld7", 1'b0, 32'd7, 32'h0, 0, 3, 32'hAAAA5555, 1'b0, 1'b0);

    // req_valid held high with changing address while busy
    acc0        = accepts;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_address = 32'd5;
    resp_ready  = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req_address = 32'd1024 + 32'(k);
      check("busy.req_ready", {31'd0, req_ready}, 32'd0);
    end
    check("busy.resp_valid", {31'd0, resp_valid}, 32'd1);
    check("busy.resp_data", resp_data, 32'hDEADBEEF);
    check("busy.resp_error", {31'd0, resp_error}, 32'd0);
    @(negedge clk);
    check("busy.accepts_first", 32'(accepts - acc0), 32'd1);
    check("busy.req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy.accepts_second", 32'(accepts - acc0), 32'd2);
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy2.resp_valid", {31'd0, resp_valid}, 32'd1);
    check("busy2.resp_error", {31'd0, resp_error}, 32'd1);
    check("busy2.resp_data", resp_data, 32'd0);
    @(negedge clk);
    check("busy2.done_req_ready", {31'd0, req_ready}, 32'd1);

`ifdef MAU_PERF_COUNTER_EN
    // Completion counters: 3 loads and 2 stores
    lc0 = load_count;
    sc0 = store_count;
    do_req("pc.ld1", 1'b0, 32'd5, 32'h0, 0, 3, 32'hDEADBEEF, 1'b0, 1'b0);
    do_req("pc.st1", 1'b1, 32'd9, 32'h99, 0, 2, 32'd0, 1'b0, 1'b1);
    do_req("pc.ld2", 1'b0, 32'd9, 32'h0, 0, 3, 32'h99, 1'b0, 1'b0);
    do_req("pc.st2", 1'b1, 32'd2000, 32'h1, 0, 2, 32'd0, 1'b1, 1'b0);
    do_req("pc.ld3", 1'b0, 32'd2000, 32'h0, 0, 3, 32'd0, 1'b1, 1'b0);
    check("pc.load_count", {16'd0, 16'(load_count - lc0)}, 32'd3);
    check("pc.store_count", {16'd0, 16'(store_count - sc0)}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
